conv_serial_stream: RTL and testbench
=====================================

# conv_serial_stream

Parametrised, streaming successor to the fixed 4x4/3x3 serial convolution filter. The block accepts a K x K kernel through a write port and an IMG_H x IMG_W image as a valid/ready pixel stream. It computes the valid-region 2-D correlation with one multiply-accumulate per cycle and returns the (IMG_H-K+1) x (IMG_W-K+1) result as a valid/ready output stream in raster order. It sits between the pixel source and the downstream result consumer in the convolution datapath.

## Interface
- DATA_W, 8: unsigned pixel and kernel coefficient width.
- IMG_W, 4: image width in pixels.
- IMG_H, 4: image height in pixels.
- K, 3: kernel edge. Elaboration error if K > IMG_W or K > IMG_H.
- ACC_W, 20: accumulator width. Must be >= 2*DATA_W + clog2(K*K).
- OUT_W, 8: output sample width.
- SAT, 1: output reduction mode. 1 = clamp to 2^OUT_W-1. 0 = keep the low OUT_W bits (wrap).

Ports (clock and reset first):
- clk  in  1  single clock. All state is updated on the rising edge.
- rst  in  1  reset, asynchronous and active-low.
- k_we  in  1  kernel write strobe. Honoured only in IDLE.
- k_addr  in  clog2(K*K)  kernel index, raster order (row*K+col). Addresses >= K*K are ignored.
- k_data  in  DATA_W  kernel coefficient.
- start  in  1  begin frame. Honoured only in IDLE.
- in_valid  in  1  pixel valid.
- in_ready  out  1  pixel ready. High only in LOAD.
- in_data  in  DATA_W  pixel, raster order.
- out_valid  out  1  result valid.
- out_ready  in  1  result accepted.
- out_data  out  OUT_W  result sample.
- out_last  out  1  high with the final result of the frame.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the final result handshake.

## Operation
- Storage:
  - kernel register file, K*K entries;
  - frame buffer, IMG_W*IMG_H entries;
  - ACC_W-bit accumulator;
  - output position counters (row, col);
  - tap counter, 0..K*K-1.
- States: IDLE, LOAD, MAC, EMIT, DONE.
- IDLE:
  - k_we writes kernel[k_addr].
  - start -> LOAD, with pixel counter cleared.
  - If k_we and start are asserted in the same cycle, both take effect.
- LOAD:
  - in_ready=1. Each in_valid&in_ready stores one pixel.
  - After IMG_W*IMG_H handshakes -> MAC, with row=col=0, tap=0, acc=0.
- MAC:
  - Each cycle: acc += pixel[row+tap/K][col+tap%K] * kernel[tap]. Arithmetic is unsigned and full-width.
  - After tap=K*K-1 -> EMIT.
- EMIT:
  - out_valid=1. out_data = reduce(acc), where reduce is selected by SAT.
  - out_last=1 iff row=IMG_H-K and col=IMG_W-K.
  - out_valid and out_data are held stable until out_ready.
  - On handshake: if this was the last result -> DONE; otherwise advance col (wrapping to 0 and incrementing row at IMG_W-K), clear acc and tap, -> MAC.
- DONE: done=1 for one cycle -> IDLE. The kernel is retained for the next frame.
- In non-IDLE states, start and k_we are ignored.
- When in_ready=0, in_valid is ignored and no pixel is consumed.
- Reset:
  - state=IDLE; kernel, counters and acc cleared.
  - in_ready, out_valid, out_data, out_last, busy and done all = 0.
  - An assertion mid-frame discards the frame. No output is produced after reset release until a new start.

## Timing
- start sampled at edge 0 -> LOAD from the next cycle; in_ready=1 from cycle 1.
- Let T be the cycle of the final pixel handshake. in_ready=0 from T+1.
- MAC occupies T+1..T+K*K. First out_valid at T+K*K+1.
- With out_ready held at 1, each result takes K*K+1 cycles.
  - Defaults: out_valid at T+10, T+20, T+30, T+40; done at T+41; IDLE at T+42.
- Output backpressure stalls the whole engine. Nothing further is computed while in EMIT.
- The frame buffer is single-buffered: no pixels are accepted between T+1 and IDLE.

## Test plan
- Kernel rows {3,0,3},{3,1,2},{1,1,1}; image rows {3,1,2,0},{3,1,2,2},{0,2,3,1},{1,3,3,2}; out_ready=1 -> outputs 34, 18, 30, 28 in order, out_last only on 28, one done pulse.
- Same frame with out_ready low for 5 cycles at the first EMIT -> out_valid stays high, out_data holds 34 and no MAC progress occurs; after release the remaining outputs are 18, 30, 28 with unchanged spacing.
- All pixels and coefficients 255 -> SAT=1: four outputs of 255. SAT=0: four outputs of 9.
- Cycle check with defaults and out_ready=1: final pixel handshake at T -> out_valid first high at T+10, done at T+41, busy low at T+42. in_valid held high after T is not consumed (in_ready=0).
- start and k_we pulsed during MAC -> no state change and kernel unchanged. A following frame run from IDLE reproduces 34, 18, 30, 28.
- rst asserted mid-MAC -> all outputs 0 immediately (asynchronous), state IDLE, kernel cleared. Reloading the kernel and frame after release gives 34, 18, 30, 28.

Source files
------------

// File: rtl/conv_serial_stream.sv
// Streaming K x K valid-region correlation over a buffered IMG_H x IMG_W frame,
// one multiply-accumulate per cycle, results returned as a valid/ready stream.
module conv_serial_stream #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 4,
    parameter int IMG_H  = 4,
    parameter int K      = 3,
    parameter int ACC_W  = 20,
    parameter int OUT_W  = 8,
    parameter int SAT    = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      k_we,
    input  logic [$clog2(K*K)-1:0]    k_addr,
    input  logic [DATA_W-1:0]         k_data,
    input  logic                      start,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OUT_W-1:0]          out_data,
    output logic                      out_last,
    output logic                      busy,
    output logic                      done,
    output logic [2:0]                dbg_state
);
    localparam int NT       = K * K;
    localparam int NPIX     = IMG_W * IMG_H;
    localparam int OUT_COLS = IMG_W - K + 1;
    localparam int OUT_ROWS = IMG_H - K + 1;
    localparam int TW = (NT > 1) ? $clog2(NT) : 1;
    localparam int PW = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int KW = (K > 1) ? $clog2(K) : 1;
    localparam int RW = (OUT_ROWS > 1) ? $clog2(OUT_ROWS) : 1;
    localparam int CW = (OUT_COLS > 1) ? $clog2(OUT_COLS) : 1;

    if (K > IMG_W || K > IMG_H) begin : g_bad_kernel
        $error("conv_serial_stream: K larger than the image");
    end
    if (ACC_W < 2 * DATA_W + $clog2(NT) || OUT_W > ACC_W) begin : g_bad_acc
        $error("conv_serial_stream: ACC_W too narrow for the kernel sum");
    end

    // Handshakes: a pixel moves when in_valid && in_ready at a rising edge, a
    // result moves when out_valid && out_ready; out_valid/out_data hold until then.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_MAC  = 3'd2,
        S_EMIT = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t              state;
    logic [DATA_W-1:0]   kernel [NT];
    logic [DATA_W-1:0]   frame  [NPIX];
    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    acc_next;
    logic [2*DATA_W-1:0] prod;
    logic [PW-1:0]       pix_cnt;
    logic [PW-1:0]       pix_addr;
    logic [RW-1:0]       row;
    logic [CW-1:0]       col;
    logic [TW-1:0]       tap;
    logic [KW-1:0]       kr;
    logic [KW-1:0]       kc;
    logic                last_pos;

    // kr/kc track tap/K and tap%K so no divider is needed.
    assign pix_addr  = PW'((32'(row) + 32'(kr)) * IMG_W + 32'(col) + 32'(kc));
    assign prod      = {{DATA_W{1'b0}}, frame[pix_addr]} * {{DATA_W{1'b0}}, kernel[tap]};
    assign acc_next  = acc + ACC_W'(prod);
    assign last_pos  = (row == RW'(OUT_ROWS - 1)) && (col == CW'(OUT_COLS - 1));
    assign dbg_state = state;

    function automatic logic [OUT_W-1:0] reduce(input logic [ACC_W-1:0] a);
        if (SAT != 0 && (a >> OUT_W) != '0) reduce = '1;
        else                                reduce = a[OUT_W-1:0];
    endfunction

    // Frame contents are don't-care until overwritten by a LOAD, so no reset.
    always_ff @(posedge clk) begin
        if (in_ready && in_valid) frame[pix_cnt] <= in_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            for (int i = 0; i < NT; i++) kernel[i] <= '0;
            acc       <= '0;
            pix_cnt   <= '0;
            row       <= '0;
            col       <= '0;
            tap       <= '0;
            kr        <= '0;
            kc        <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (k_we && (32'(k_addr) < NT)) kernel[k_addr] <= k_data;
                    if (start) begin
                        state    <= S_LOAD;
                        pix_cnt  <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (in_valid) begin
                        pix_cnt <= pix_cnt + 1'b1;
                        if (pix_cnt == PW'(NPIX - 1)) begin
                            in_ready <= 1'b0;
                            state    <= S_MAC;
                            row      <= '0;
                            col      <= '0;
                            tap      <= '0;
                            kr       <= '0;
                            kc       <= '0;
                            acc      <= '0;
                        end
                    end
                end
                S_MAC: begin
                    acc <= acc_next;
                    if (tap == TW'(NT - 1)) begin
                        tap       <= '0;
                        kr        <= '0;
                        kc        <= '0;
                        state     <= S_EMIT;
                        out_valid <= 1'b1;
                        out_data  <= reduce(acc_next);
                        out_last  <= last_pos;
                    end else begin
                        tap <= tap + 1'b1;
                        if (kc == KW'(K - 1)) begin
                            kc <= '0;
                            kr <= kr + 1'b1;
                        end else begin
                            kc <= kc + 1'b1;
                        end
                    end
                end
                S_EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (out_last) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            acc   <= '0;
                            state <= S_MAC;
                            if (col == CW'(OUT_COLS - 1)) begin
                                col <= '0;
                                row <= row + 1'b1;
                            end else begin
                                col <= col + 1'b1;
                            end
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_serial_stream.sv
// Bench for conv_serial_stream: directed frames from the test plan plus random
// frames checked against a direct sum-of-products reference.
module tb_conv_serial_stream;
    localparam int NT = 9;
    localparam int NP = 16;
    localparam int NR = 4;
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_MAC  = 3'd2;
    localparam logic [2:0] ST_EMIT = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       k_we = 1'b0;
    logic [3:0] k_addr = '0;
    logic [7:0] k_data = '0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       out_ready = 1'b0;
    logic       in_ready, out_valid, out_last, busy, done;
    logic [7:0] out_data;
    logic [2:0] dbg_state;
    logic       w_in_ready, w_out_valid, w_out_last, w_busy, w_done;
    logic [7:0] w_out_data;
    logic [2:0] w_dbg_state;

    always #5 clk = ~clk;

    conv_serial_stream #(.SAT(1)) dut (
        .clk(clk), .rst(rst), .k_we(k_we), .k_addr(k_addr), .k_data(k_data),
        .start(start), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .done(done), .dbg_state(dbg_state)
    );

    conv_serial_stream #(.SAT(0)) dut_w (
        .clk(clk), .rst(rst), .k_we(k_we), .k_addr(k_addr), .k_data(k_data),
        .start(start), .in_valid(in_valid), .in_ready(w_in_ready), .in_data(in_data),
        .out_valid(w_out_valid), .out_ready(out_ready), .out_data(w_out_data),
        .out_last(w_out_last), .busy(w_busy), .done(w_done), .dbg_state(w_dbg_state)
    );

    int total = 0;
    int bad = 0;
    int ker_m [NT];
    int img_m [NP];
    logic [7:0] exp_q [$];
    logic [7:0] exp_w_q [$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string tag);
        total++;
        bad++;
        $error("FAIL %s observed=timeout expected=completion", tag);
    endtask

    task automatic set_spec();
        ker_m = '{3, 0, 3, 3, 1, 2, 1, 1, 1};
        img_m = '{3, 1, 2, 0, 3, 1, 2, 2, 0, 2, 3, 1, 1, 3, 3, 2};
    endtask

    task automatic expect_const(input int a, input int b, input int c, input int d);
        exp_q.delete();
        exp_w_q.delete();
        exp_q.push_back(8'(a)); exp_q.push_back(8'(b));
        exp_q.push_back(8'(c)); exp_q.push_back(8'(d));
        exp_w_q = exp_q;
    endtask

    // Reference: plain sum over each 3x3 window, then clamp or wrap.
    task automatic expect_model();
        int s;
        exp_q.delete();
        exp_w_q.delete();
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 2; c++) begin
                s = 0;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        s += img_m[(r + i) * 4 + c + j] * ker_m[i * 3 + j];
                exp_q.push_back(s > 255 ? 8'd255 : 8'(s));
                exp_w_q.push_back(8'(s));
            end
        end
    endtask

    task automatic write_kernel(input int n);
        for (int i = 0; i < n; i++) begin
            k_we = 1'b1;
            k_addr = 4'(i);
            k_data = 8'(ker_m[i]);
            step();
        end
        k_we = 1'b1;
        k_addr = 4'($urandom_range(9, 15));
        k_data = 8'($urandom);
        step();
        k_we = 1'b0;
    endtask

    task automatic load_pixels(input bit gaps, input bit hold, output bit ok);
        int idx;
        int guard;
        bit hs;
        idx = 0;
        guard = 0;
        while (idx < NP && guard < 400) begin
            in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_data = 8'(img_m[idx]);
            hs = in_valid && in_ready;
            step();
            guard++;
            if (hs) idx++;
        end
        in_valid = hold;
        in_data = 8'($urandom);
        ok = (idx == NP);
        if (!ok) timeout_fail("load_pixels");
    endtask

    task automatic run_frame(input bit gaps, input bit bp, input bit stall, input bit hold,
                             input bit poke, input bit kw8, input bit timed);
        bit ok;
        bit seen;
        int n, gap, since_t, guard, stall_cnt;
        start = 1'b1;
        if (kw8) begin
            k_we = 1'b1;
            k_addr = 4'd8;
            k_data = 8'(ker_m[8]);
        end
        step();
        start = 1'b0;
        k_we = 1'b0;
        chk("busy_start", 32'(busy), 1);
        chk("in_ready_load", 32'(in_ready), 1);
        chk("w_in_ready_load", 32'(w_in_ready), 1);
        load_pixels(gaps, hold, ok);
        if (!ok) return;
        chk("in_ready_after_t", 32'(in_ready), 0);
        chk("state_mac", 32'(dbg_state), 32'(ST_MAC));
        n = 0; gap = 0; since_t = 0; guard = 0; seen = 1'b0; stall_cnt = 0;
        while (n < NR && guard < 3000) begin
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stall && n == 0 && out_valid && stall_cnt < 5) begin
                out_ready = 1'b0;
                stall_cnt++;
                chk("stall_data", 32'(out_data), 34);
                chk("stall_state", 32'(dbg_state), 32'(ST_EMIT));
            end
            if (poke && n == 0 && gap == 2) begin
                start = 1'b1;
                k_we = 1'b1;
                k_addr = 4'd0;
                k_data = 8'hAA;
            end
            if (poke && n == 0 && gap == 3) begin
                start = 1'b0;
                k_we = 1'b0;
                chk("poke_state", 32'(dbg_state), 32'(ST_MAC));
                chk("poke_busy", 32'(busy), 1);
            end
            if (out_valid && !seen) begin
                seen = 1'b1;
                chk("result_gap", 32'(gap), (n == 0) ? 9 : 10);
            end
            if (out_valid && out_ready) begin
                chk("out_data", 32'(out_data), 32'(exp_q.pop_front()));
                chk("out_data_wrap", 32'(w_out_data), 32'(exp_w_q.pop_front()));
                chk("out_last", 32'(out_last), 32'(n == NR - 1));
                chk("out_last_wrap", 32'(w_out_last), 32'(n == NR - 1));
                n++;
                seen = 1'b0;
                gap = 0;
            end
            step();
            gap++;
            since_t++;
            guard++;
        end
        out_ready = 1'b1;
        in_valid = 1'b0;
        if (n < NR) begin
            timeout_fail("results");
            return;
        end
        chk("done_pulse", 32'(done), 1);
        chk("done_pulse_wrap", 32'(w_done), 1);
        chk("state_done", 32'(dbg_state), 32'(ST_DONE));
        if (timed) chk("done_cycle", 32'(since_t), 40);
        step();
        chk("done_low", 32'(done), 0);
        chk("busy_idle", 32'(busy), 0);
        chk("busy_idle_wrap", 32'(w_busy), 0);
        chk("state_idle", 32'(dbg_state), 32'(ST_IDLE));
        chk("in_ready_idle", 32'(in_ready), 0);
    endtask

    initial begin
        bit ok;
        int hi;
        bit kw8;

        step();
        step();
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_last", 32'(out_last), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        rst = 1'b1;
        step();

        // Reference frame with exact cycle positions; in_valid left high after T.
        set_spec();
        write_kernel(NT);
        expect_const(34, 18, 30, 28);
        run_frame(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);

        // Five-cycle stall at the first result.
        expect_const(34, 18, 30, 28);
        run_frame(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // start/k_we pulsed during MAC, random gaps and backpressure.
        expect_const(34, 18, 30, 28);
        run_frame(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_const(34, 18, 30, 28);
        run_frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Full-scale inputs: clamp vs wrap.
        for (int i = 0; i < NT; i++) ker_m[i] = 255;
        for (int i = 0; i < NP; i++) img_m[i] = 255;
        write_kernel(NT);
        exp_q.delete();
        exp_w_q.delete();
        for (int i = 0; i < NR; i++) begin
            exp_q.push_back(8'd255);
            exp_w_q.push_back(8'd9);
        end
        run_frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset in the middle of MAC.
        set_spec();
        start = 1'b1;
        step();
        start = 1'b0;
        load_pixels(1'b0, 1'b0, ok);
        step();
        step();
        step();
        chk("pre_reset_state", 32'(dbg_state), 32'(ST_MAC));
        #3 rst = 1'b0;
        #1;
        chk("arst_state", 32'(dbg_state), 32'(ST_IDLE));
        chk("arst_busy", 32'(busy), 0);
        chk("arst_out_valid", 32'(out_valid), 0);
        chk("arst_out_data", 32'(out_data), 0);
        chk("arst_in_ready", 32'(in_ready), 0);
        chk("arst_done", 32'(done), 0);
        step();
        rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("post_rst_quiet", 32'({out_valid, busy}), 0);
        end
        for (int i = 0; i < NT; i++) ker_m[i] = 0;
        expect_model();
        run_frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        set_spec();
        write_kernel(NT);
        expect_const(34, 18, 30, 28);
        run_frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Random frames against the reference.
        for (int it = 0; it < 6; it++) begin
            hi = (it % 2 == 1) ? 255 : 12;
            for (int i = 0; i < NT; i++) ker_m[i] = $urandom_range(0, hi);
            for (int i = 0; i < NP; i++) img_m[i] = $urandom_range(0, hi);
            kw8 = 1'($urandom_range(0, 1));
            write_kernel(kw8 ? 8 : NT);
            expect_model();
            run_frame(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, kw8, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
